// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_pkg;

  localparam logic [31:0] IF_RESET_PC = 32'hBFC00000;
  localparam logic [31:0] IF_NOP      = 32'h0;

  localparam logic [0:0] IF_FETCH = 1'b0;
  localparam logic [0:0] IF_HOLD  = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_beat_t;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction bus between the fetch stage (master) and memory (slave).
interface if_fetch_if;

  logic [31:0] ibus_address;
  logic        ibus_read;
  logic [31:0] ibus_rddata;
  logic        ibus_stall;

  modport master (output ibus_address, ibus_read, input ibus_rddata, ibus_stall);
  modport slave  (input ibus_address, ibus_read, output ibus_rddata, ibus_stall);

endinterface

// File: rtl/if_fetch_hold_buf.sv
// One-entry skid buffer holding a fetched beat while ID back-pressures.
module if_fetch_hold_buf
  import if_fetch_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load_i,
  input  logic     drain_i,
  input  logic     flush_i,
  input  if_beat_t beat_i,
  output if_beat_t beat_o,
  output logic     valid_o
);

  if_beat_t beat_q;
  logic     valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (drain_i || flush_i) valid_d = 1'b0;
    if (load_i)             valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load_i) beat_q <= beat_i;
      valid_q <= valid_d;
    end
  end

  assign beat_o  = beat_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, ibus drive, delay-slot branch steering, flush.
// Optional IFETCH_ADEL_EN adds misaligned-fetch detection (if_adel output).
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_stall,
  input  logic              flush,
  input  logic [31:0]       flush_pc,
  input  logic              is_branch,
  input  logic              branch_taken,
  input  logic [31:0]       branch_address,
  if_fetch_if.master        ibus,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  output logic              if_valid,
  output logic              if_stall_req
`ifdef IFETCH_ADEL_EN
  ,
  output logic              if_adel
`endif
);

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        discard_q, discard_d;
`ifdef IFETCH_ADEL_EN
  logic        if_adel_q, if_adel_d;
  logic        hold_adel_q, hold_adel_d;
`endif

  logic        misalign, complete, outstanding, br_take;
  logic        fetch_adv, hold_adv, hold_load;
  logic [31:0] fetch_word, next_pc;
  if_beat_t    hold_beat;
  logic        hold_valid;

`ifdef IFETCH_ADEL_EN
  assign misalign = (pc_q[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign fetch_word        = misalign ? IF_NOP : ibus.ibus_rddata;
  assign ibus.ibus_address = pc_q;
  assign ibus.ibus_read    = (state_q == IF_FETCH) && !misalign;
  assign if_stall_req      = ibus.ibus_read && ibus.ibus_stall;

  assign complete    = (state_q == IF_FETCH) && (misalign || !ibus.ibus_stall);
  assign outstanding = (state_q == IF_FETCH) && !complete;
  assign br_take     = is_branch && branch_taken && if_valid_q;
  assign fetch_adv   = complete && !id_stall && !discard_q;
  assign hold_adv    = (state_q == IF_HOLD) && hold_valid && !id_stall;
  assign hold_load   = complete && id_stall && !discard_q && !flush;

  always_comb begin
    if (flush)             next_pc = flush_pc;
    else if (pend_valid_q) next_pc = pend_pc_q;
    else if (br_take)      next_pc = branch_address;
    else                   next_pc = pc_q + 32'd4;
  end

  if_fetch_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (hold_load),
    .drain_i (hold_adv && !flush),
    .flush_i (flush),
    .beat_i  ('{pc: pc_q, inst: fetch_word}),
    .beat_o  (hold_beat),
    .valid_o (hold_valid)
  );

  // A flush that lands on an outstanding beat cannot move the PC yet: the bus
  // still owns that address, so the target parks in pend_pc until it drains.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_pc_d      = if_pc_q;
    if_inst_d    = if_inst_q;
    if_valid_d   = if_valid_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    discard_d    = discard_q;
`ifdef IFETCH_ADEL_EN
    if_adel_d    = if_adel_q;
    hold_adel_d  = hold_adel_q;
`endif
    if (flush) begin
      if_valid_d = 1'b0;
`ifdef IFETCH_ADEL_EN
      if_adel_d  = 1'b0;
`endif
      if (outstanding) begin
        pend_pc_d    = flush_pc;
        pend_valid_d = 1'b1;
        discard_d    = 1'b1;
      end else begin
        pc_d         = flush_pc;
        pend_valid_d = 1'b0;
        discard_d    = 1'b0;
        state_d      = IF_FETCH;
      end
    end else if (complete && discard_q) begin
      discard_d    = 1'b0;
      pc_d         = pend_pc_q;
      pend_valid_d = 1'b0;
      if_valid_d   = 1'b0;
    end else if (fetch_adv || hold_adv) begin
      if_pc_d      = fetch_adv ? pc_q : hold_beat.pc;
      if_inst_d    = fetch_adv ? fetch_word : hold_beat.inst;
      if_valid_d   = 1'b1;
      pc_d         = next_pc;
      pend_valid_d = 1'b0;
      state_d      = IF_FETCH;
`ifdef IFETCH_ADEL_EN
      if_adel_d    = fetch_adv ? misalign : hold_adel_q;
`endif
    end else begin
      if (hold_load) begin
        state_d = IF_HOLD;
`ifdef IFETCH_ADEL_EN
        hold_adel_d = misalign;
`endif
      end
      if (br_take) begin
        pend_pc_d    = branch_address;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IF_FETCH;
      pc_q         <= RESET_PC;
      if_pc_q      <= '0;
      if_inst_q    <= '0;
      if_valid_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      discard_q    <= 1'b0;
`ifdef IFETCH_ADEL_EN
      if_adel_q    <= 1'b0;
      hold_adel_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_pc_q      <= if_pc_d;
      if_inst_q    <= if_inst_d;
      if_valid_q   <= if_valid_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      discard_q    <= discard_d;
`ifdef IFETCH_ADEL_EN
      if_adel_q    <= if_adel_d;
      hold_adel_q  <= hold_adel_d;
`endif
    end
  end

  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_valid = if_valid_q;
`ifdef IFETCH_ADEL_EN
  assign if_adel  = if_adel_q;
`endif

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that directly feeds the ID-stage branch resolver.
- Owns the PC register and drives the instruction bus. Delivers a registered {pc, inst, valid} triple to ID.
- Consumes the branch unit's is_branch/branch_taken/branch_address to steer the next fetch after the delay slot.
- Handles bus wait states, ID back-pressure and exception redirects.

Parameters:
- RESET_PC, 32'hBFC00000, PC loaded on reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- id_stall  in  1  ID cannot accept a new instruction this cycle
- flush  in  1  exception/ERET redirect, highest priority
- flush_pc  in  32  redirect target
- is_branch  in  1  ID instruction is a branch/jump
- branch_taken  in  1  ID branch resolved taken
- branch_address  in  32  resolved target
- ibus_address  out  32  fetch address
- ibus_read  out  1  fetch request
- ibus_rddata  in  32  fetched word, valid when ibus_read and !ibus_stall
- ibus_stall  in  1  bus wait state
- if_pc  out  32  PC of the instruction presented to ID
- if_inst  out  32  instruction presented to ID
- if_valid  out  1  if_pc/if_inst hold a real instruction
- if_stall_req  out  1  to hazard unit: fetch outstanding (ibus_read & ibus_stall)

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, if_pc=0, if_inst=0, if_valid=0, pend_valid=0, pend_pc=0, discard=0.
- Combinational bus drive: ibus_address=pc. ibus_read=1 in FETCH, 0 in HOLD. The address must stay stable while ibus_stall=1.
- Branch inputs are honoured only when if_valid=1. The branch unit's outputs are ignored behind a bubble.
- next_pc priority:
  - flush -> flush_pc
  - pend_valid -> pend_pc
  - branch_taken&if_valid -> branch_address
  - else pc+4 (mod 2^32; wrap from FFFFFFFC to 0 is legal)
- "complete" = FETCH & !ibus_stall. "advance" = complete & !id_stall & !discard, or HOLD & !id_stall.
- FETCH state:
  - On advance: if_pc<=pc, if_inst<=ibus_rddata, if_valid<=1, pc<=next_pc, pend_valid<=0.
  - On complete&id_stall: latch the word into hold_inst/hold_pc, go to HOLD. pc is unchanged.
  - On complete&discard: drop the word, discard<=0, pc<=pend_pc, pend_valid<=0, if_valid<=0.
- HOLD state:
  - No bus request.
  - When !id_stall: if_pc<=hold_pc, if_inst<=hold_inst, if_valid<=1, pc<=next_pc, return to FETCH.
- Branch capture: if branch_taken&if_valid and no advance this cycle, pend_pc<=branch_address, pend_valid<=1. Sole purpose: the target must survive the delay-slot fetch across stalls.
- Delay slot: the instruction fetched while the branch is in ID is always delivered. The redirect applies to the fetch after it.
- Flush while idle (no outstanding beat): pc<=flush_pc, if_valid<=0, pend_valid<=0, HOLD->FETCH. One bubble.
- Flush during ibus_stall:
  - pend_pc<=flush_pc, pend_valid<=1, discard<=1.
  - The stalled beat completes and is dropped. Fetch then restarts at flush_pc.
  - A flush overrides any pending branch.
- Flush and branch_taken in the same cycle: flush wins, and the branch is dropped.
- Latency: one cycle from bus completion to if_valid. Back-to-back issue with zero wait states gives 1 instruction/cycle.
- id_stall with if_valid=1 holds if_pc/if_inst/if_valid stable.
- rst overrides everything in the same cycle, including mid-stall. The bus-side abort is the bus's responsibility.

Optional Feature:
- Macro: IFETCH_ADEL_EN.
- Defined:
  - Adds output if_adel (1 bit, reset 0).
  - If pc[1:0]!=0 in FETCH, ibus_read=0. The stage treats the fetch as an immediate complete with inst=32'h0 and if_adel=1 on the delivered triple.
  - if_adel clears on the next advance or flush.
- Undefined: no port; pc[1:0] are forwarded to the bus unchecked.

Decomposition:
- Shared package holds:
  - RESET_PC default
  - state encoding (IF_FETCH=1'b0, IF_HOLD=1'b1)
  - NOP word 32'h0
- A one-entry skid buffer sub-module (if_hold_buf: load, drain, flush, data/pc/valid) is natural. The rest stays flat.

Test Plan:
- Reset, then 4 cycles with zero wait states -> ibus_address BFC00000, 04, 08, 0C. if_valid rises 1 cycle after the first read, with if_pc trailing by one.
- ID holds BEQ at 0x100, taken, target 0x200 -> delay slot 0x104 delivered; next ibus_address=0x200; 0x108 never requested.
- Same branch with ibus_stall=1 for 3 cycles on 0x104 -> pend_valid set; after completion ibus_address=0x200.
- id_stall=1 for 2 cycles as a fetch completes -> enters HOLD, ibus_read=0, word delivered unchanged when the stall drops, no refetch.
- flush (flush_pc=0x80000180) during ibus_stall on 0x40 -> the 0x40 word is discarded, if_valid=0, next request at 0x80000180.
- With IFETCH_ADEL_EN, jump target 0x202 -> ibus_read=0 at 0x202, if_adel=1, if_inst=0, if_pc=0x202.
